motor_pwm_bank: RTL

Parametrised multi-channel PWM motor driver; successor to the single-channel fixed-10-bit PWM wrapper. Each channel accepts duty/direction/brake commands over a valid/ready handshake and produces H-bridge drive pulses (`pulse_h` forward, `pulse_g` reverse). Duty changes are slew-limited at period boundaries, and direction reversals are sequenced safely through zero plus a dead period. Sits between the PS-PL register interface and the motor-driver pins.

---
 rtl/motor_pwm_pkg.sv | 24 ++
 rtl/motor_pwm_chan.sv | 127 ++++++++++++
 rtl/motor_pwm_bank.sv | 62 ++++++
 3 files changed

// File: rtl/motor_pwm_pkg.sv
// Shared types for the multi-channel motor PWM bank: channel FSM states,
// direction encoding and small state-classification helpers.
package motor_pwm_pkg;

  typedef enum logic [2:0] {
    ST_COAST,
    ST_RUN,
    ST_RAMP_DOWN,
    ST_DEAD,
    ST_BRAKE
  } chan_state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  function automatic logic accepts_cmd(input chan_state_t s);
    return (s == ST_COAST) || (s == ST_RUN) || (s == ST_BRAKE);
  endfunction

  function automatic logic drives_bridge(input chan_state_t s);
    return (s == ST_RUN) || (s == ST_RAMP_DOWN);
  endfunction

endpackage

// File: rtl/motor_pwm_chan.sv
// One motor channel: command handshake, slew-limited duty ramp, safe
// reversal through zero plus dead periods, and H-bridge output steering.
module motor_pwm_chan
  import motor_pwm_pkg::*;
#(
  parameter int W    = 10,
  parameter int STEP = 8,
  parameter int DEAD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [W-1:0] cnt,
  input  logic        boundary,
  input  logic        cmd_valid,
  input  logic [W-1:0] cmd_duty,
  input  logic        cmd_dir,
  input  logic        cmd_brake,
  output logic        cmd_ready,
  output logic        pulse_h,
  output logic        pulse_g,
  output logic        busy,
  output chan_state_t state_dbg
);

  localparam int DW = (DEAD > 1) ? $clog2(DEAD) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD - 1);
  localparam logic [W:0] STEP_X = (W+1)'(STEP);

  chan_state_t  state;
  logic [W-1:0] cur;
  logic [W-1:0] tgt;
  logic         dir;
  logic         req_dir;
  logic [DW-1:0] dead_cnt;
  logic         accept;
  logic [W-1:0] goal;
  logic [W-1:0] cur_next;

  // Handshake: a command transfers on any cycle where cmd_valid and
  // cmd_ready are both high; ready depends only on registered state, never
  // on valid, and is low for the whole reversal (ramp-down plus dead time).
  assign cmd_ready = accepts_cmd(state);
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state == ST_RAMP_DOWN) || (state == ST_DEAD) ||
                     ((state == ST_RUN) && (cur != tgt));
  assign state_dbg = state;

  // One ramp step toward the goal, computed one bit wider so it never wraps.
  always_comb begin
    goal     = (state == ST_RAMP_DOWN) ? '0 : tgt;
    cur_next = goal;
    if ({1'b0, goal} > ({1'b0, cur} + STEP_X)) begin
      cur_next = W'({1'b0, cur} + STEP_X);
    end else if ({1'b0, cur} > ({1'b0, goal} + STEP_X)) begin
      cur_next = W'({1'b0, cur} - STEP_X);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_COAST;
      cur      <= '0;
      tgt      <= '0;
      dir      <= DIR_FWD;
      req_dir  <= DIR_FWD;
      dead_cnt <= '0;
      pulse_h  <= 1'b0;
      pulse_g  <= 1'b0;
    end else begin
      pulse_h <= 1'b0;
      pulse_g <= 1'b0;
      if (drives_bridge(state) && (cnt < cur)) begin
        if (dir == DIR_REV) pulse_g <= 1'b1;
        else                pulse_h <= 1'b1;
      end
      if (accept ? cmd_brake : (state == ST_BRAKE)) begin
        pulse_h <= 1'b1;
        pulse_g <= 1'b1;
      end

      if (boundary) begin
        case (state)
          ST_RUN: begin
            if ((cur == '0) && (tgt == '0)) state <= ST_COAST;
            else                            cur   <= cur_next;
          end
          ST_RAMP_DOWN: begin
            if (cur == '0) begin
              state    <= ST_DEAD;
              dead_cnt <= '0;
            end else begin
              cur <= cur_next;
            end
          end
          ST_DEAD: begin
            if (dead_cnt == DEAD_LAST) begin
              state <= ST_RUN;
              dir   <= req_dir;
            end else begin
              dead_cnt <= dead_cnt + DW'(1);
            end
          end
          default: ;
        endcase
      end

      // A command overrides the boundary's state decision; the ramp above
      // has already used the pre-command target for this boundary.
      if (accept) begin
        if (cmd_brake) begin
          state <= ST_BRAKE;
          cur   <= '0;
        end else begin
          tgt     <= cmd_duty;
          req_dir <= cmd_dir;
          if ((state == ST_RUN) && (cmd_dir != dir)) begin
            state <= ST_RAMP_DOWN;
          end else begin
            state <= ST_RUN;
            dir   <= cmd_dir;
          end
        end
      end
    end
  end

endmodule

// File: rtl/motor_pwm_bank.sv
// Multi-channel PWM motor driver: shared period counter and period strobe,
// one independent channel per motor.
module motor_pwm_bank
  import motor_pwm_pkg::*;
#(
  parameter int CH   = 2,
  parameter int W    = 10,
  parameter int STEP = 8,
  parameter int DEAD = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH-1:0]        cmd_valid,
  output logic [CH-1:0]        cmd_ready,
  input  logic [CH*W-1:0]      cmd_duty,
  input  logic [CH-1:0]        cmd_dir,
  input  logic [CH-1:0]        cmd_brake,
  output logic [CH-1:0]        pulse_h,
  output logic [CH-1:0]        pulse_g,
  output logic [CH-1:0]        busy,
  output logic                 period_start,
  output chan_state_t [CH-1:0] dbg_state
);

  logic [W-1:0] cnt;
  logic         boundary;

  assign boundary = (cnt == {W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt + W'(1);
      period_start <= boundary;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    motor_pwm_chan #(
      .W    (W),
      .STEP (STEP),
      .DEAD (DEAD)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .cnt       (cnt),
      .boundary  (boundary),
      .cmd_valid (cmd_valid[i]),
      .cmd_duty  (cmd_duty[i*W +: W]),
      .cmd_dir   (cmd_dir[i]),
      .cmd_brake (cmd_brake[i]),
      .cmd_ready (cmd_ready[i]),
      .pulse_h   (pulse_h[i]),
      .pulse_g   (pulse_g[i]),
      .busy      (busy[i]),
      .state_dbg (dbg_state[i])
    );
  end

endmodule
